vector_component_packer: RTL and testbench

//  Inverse of the vector-register component extractor. Takes screen-space pixel

---
 rtl/vector_component_packer.sv | 171 +++++++++++++++++
 tb/tb_vector_component_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vector_component_packer.sv
// ---------------------------------------------------------------------------
// vector_component_packer
//   Rebuilds a 64-bit vector register value from screen-space pixel coords
//   plus two raw components. x/y go back to sign-magnitude fixed point
//   (bit15 sign, [14:0] magnitude, 7 fraction bits):
//     x = 2*px - ORIGIN
//     y = ORIGIN - floor((16*py + 2) / 5)
//   The y scale of 16/5 uses a serial restoring divider, one step per clock.
//   Fields saturate to 0x7FFF magnitude, and zero never carries a sign.
//
// Ports
//   clock, reset       rising-edge clock, async active-high reset
//   in_valid/in_ready  input handshake (ready only while idle)
//   in_component0..3   comp0, comp1, pixel y, pixel x (bit15 of x/y ignored)
//   out_valid/out_ready output handshake
//   out_vector_val     {x_fix, y_fix, comp1, comp0}
//   out_saturated      (only with VPACK_SAT_FLAG_EN) x or y was clamped
//
// Build option: define VPACK_SAT_FLAG_EN to add the out_saturated port.
// ---------------------------------------------------------------------------
module vector_component_packer #(
    parameter int ORIGIN    = 640,
    parameter int DIV_STEPS = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_component0,
    input  logic [15:0] in_component1,
    input  logic [15:0] in_component2,
    input  logic [15:0] in_component3,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef VPACK_SAT_FLAG_EN
    output logic        out_saturated,
`endif
    output logic [63:0] out_vector_val
);

    localparam int IW = $clog2(DIV_STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FMT  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [14:0]   px_q, px_d;
    logic [15:0]   c0_q, c0_d, c1_q, c1_d;
    logic [18:0]   num_q, num_d;   // dividend, shifted out MSB first
    logic [3:0]    rem_q, rem_d;   // partial remainder, always < 5
    logic [16:0]   quo_q, quo_d;
    logic [63:0]   out_q, out_d;
    logic          ov_q, ov_d;
    logic          sat_q, sat_d;

    // Sign bits of the pixel coordinates carry no information here.
    logic unused_sign_bits;
    assign unused_sign_bits = in_component2[15] ^ in_component3[15];

    // Sign-magnitude conversion with clamp; returns {clamped, field}.
    function automatic logic [16:0] to_fix(input logic signed [17:0] d);
        logic [17:0] mag;
        logic        neg;
        neg = d[17];
        mag = neg ? 18'(-d) : 18'(d);
        if (mag > 18'h07FFF) to_fix = {1'b1, neg, 15'h7FFF};
        else                 to_fix = {1'b0, neg, mag[14:0]};
    endfunction

    logic [4:0]         trial;
    logic               qbit;
    logic signed [17:0] xd, yd;
    logic [16:0]        xf, yf;

    always_comb begin
        // One restoring step: bring in the next dividend bit, subtract 5 if it fits.
        trial = {rem_q, num_q[18]};
        qbit  = (trial >= 5'd5);

        xd = 18'($signed({2'b00, px_q, 1'b0})) - 18'(ORIGIN);
        yd = 18'(ORIGIN) - $signed({1'b0, quo_q});
        xf = to_fix(xd);
        yf = to_fix(yd);

        state_d = state_q;
        iter_d  = iter_q;
        px_d    = px_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        num_d   = num_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        out_d   = out_q;
        ov_d    = ov_q;
        sat_d   = sat_q;

        case (state_q)
            S_IDLE: if (in_valid) begin
                px_d    = in_component3[14:0];
                c0_d    = in_component0;
                c1_d    = in_component1;
                num_d   = {in_component2[14:0], 4'b0010};  // 16*py + 2
                rem_d   = '0;
                quo_d   = '0;
                iter_d  = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d  = qbit ? 4'(trial - 5'd5) : trial[3:0];
                quo_d  = {quo_q[15:0], qbit};
                num_d  = {num_q[17:0], 1'b0};
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(DIV_STEPS - 1)) state_d = S_FMT;
            end
            S_FMT: begin
                out_d   = {xf[15:0], yf[15:0], c1_q, c0_q};
                sat_d   = xf[16] | yf[16];
                ov_d    = 1'b1;
                state_d = S_HOLD;
            end
            default: if (out_ready) begin
                ov_d    = 1'b0;
                sat_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            px_q    <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            px_q    <= px_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign out_valid      = ov_q;
    assign out_vector_val = out_q;

`ifdef VPACK_SAT_FLAG_EN
    assign out_saturated = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_vector_component_packer.sv
module tb_vector_component_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_component0 = '0, in_component1 = '0;
    logic [15:0] in_component2 = '0, in_component3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_vector_val;
`ifdef VPACK_SAT_FLAG_EN
    logic        out_saturated;
`endif

    int nchk  = 0;
    int nfail = 0;

    vector_component_packer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_component0(in_component0), .in_component1(in_component1),
        .in_component2(in_component2), .in_component3(in_component3),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef VPACK_SAT_FLAG_EN
        .out_saturated(out_saturated),
`endif
        .out_vector_val(out_vector_val)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] px, input logic [15:0] py,
                         input logic [15:0] c1, input logic [15:0] c0);
        in_component3 = px;
        in_component2 = py;
        in_component1 = c1;
        in_component0 = c0;
        in_valid      = 1'b1;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_out(input string tag, input logic [63:0] exp, input logic exp_sat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd20);
        chk({tag, " data"}, out_vector_val, exp);
`ifdef VPACK_SAT_FLAG_EN
        chk({tag, " sat"}, 64'(out_saturated), 64'(exp_sat));
`else
        if (exp_sat) begin end
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid clr"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_word(input string tag, input logic [15:0] px, input logic [15:0] py,
                            input logic [15:0] c1, input logic [15:0] c0,
                            input logic [63:0] exp, input logic exp_sat, input logic early);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        drive(px, py, c1, c0);
        out_ready = early;  // early ready must not complete anything
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk({tag, " busy"}, 64'(in_ready), 64'd0);
        wait_out(tag, exp, exp_sat);
        handshake(tag);
    endtask

    initial begin
        logic [63:0] held;

        // Reset state
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_val", out_vector_val, 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: centre of plane -> both fields zero, comps pass through
        run_word("t1", 16'd320, 16'd200, 16'hBEEF, 16'h1234, 64'h0000_0000_BEEF_1234, 1'b0, 1'b0);
        // 2: origin corner, x sign bit set on input must be ignored
        run_word("t2", 16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 64'h8280_0280_0000_FFFF, 1'b0, 1'b1);
        // 3: opposite corner and a rounded y
        run_word("t3a", 16'd640, 16'd400, 16'h0F0F, 16'hF0F0, 64'h0280_8280_0F0F_F0F0, 1'b0, 1'b0);
        run_word("t3b", 16'd320, 16'd1, 16'h0001, 16'h0002, 64'h0000_027D_0001_0002, 1'b0, 1'b0);
        // 4: both saturate
        run_word("t4", 16'h7FFF, 16'h7FFF, 16'hA5A5, 16'h5A5A, 64'h7FFF_FFFF_A5A5_5A5A, 1'b1, 1'b0);
        // x just under the clamp: 2*16703-640 = 32766
        run_word("t4b", 16'd16703, 16'd0, 16'h0000, 16'h0000, 64'h7FFE_0280_0000_0000, 1'b0, 1'b0);

        // 5: back-pressure with a new word held on the input
        drive(16'd400, 16'd100, 16'h1111, 16'h2222);
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_out("t5a", 64'h00A0_0140_1111_2222, 1'b0);
        held = out_vector_val;
        drive(16'd16703, 16'd320, 16'h3333, 16'h4444);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("t5 stall in_ready", 64'(in_ready), 64'd0);
            chk("t5 stall out_valid", 64'(out_valid), 64'd1);
            chk("t5 stall data", out_vector_val, held);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("t5 clr", 64'(out_valid), 64'd0);
        chk("t5 idle", 64'(in_ready), 64'd1);
        @(posedge clock); #1;   // held in_valid is accepted here
        in_valid = 1'b0;
        chk("t5 accept", 64'(in_ready), 64'd0);
        wait_out("t5b", 64'h7FFE_8180_3333_4444, 1'b0);
        handshake("t5b");

        // 6: reset during divide
        drive(16'd100, 16'd50, 16'h7777, 16'h8888);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("t6 rst out_valid", 64'(out_valid), 64'd0);
        chk("t6 rst out_val", out_vector_val, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6 in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        run_word("t6", 16'd320, 16'd1, 16'hCAFE, 16'h0001, 64'h0000_027D_CAFE_0001, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
